mc_sync_fifo: RTL and testbench

Single-clock, multi-channel FIFO. NUM_CH independent logical FIFOs share one dual-port storage array, partitioned into equal regions of 2**ADDR_WIDTH entries each. Each channel has its own pointers, full/empty/almost-full flags and a flush. The block serves as the same-clock-domain buffering stage beside the async FIFO path, used where several producer streams are muxed onto one consumer.

---
 rtl/mc_fifo_pkg.sv | 25 ++
 rtl/mc_fifo_ram.sv | 26 ++
 rtl/mc_sync_fifo.sv | 114 +++++++++++
 tb/tb_mc_sync_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_fifo_pkg.sv
// Shared constants, pointer type and pointer-arithmetic helpers for the multi-channel FIFO.
package mc_fifo_pkg;

    localparam int unsigned PKG_DATA_WIDTH = 8;
    localparam int unsigned PKG_ADDR_WIDTH = 4;
    localparam int unsigned PKG_NUM_CH     = 4;
    localparam int unsigned PKG_AFULL_LVL  = 12;

    // One extra bit above the address distinguishes full from empty when low bits match.
    typedef logic [PKG_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t occupancy(input ptr_t wptr, input ptr_t rptr);
        return wptr - rptr;
    endfunction

    function automatic logic is_empty(input ptr_t wptr, input ptr_t rptr);
        return wptr == rptr;
    endfunction

    function automatic logic is_full(input ptr_t wptr, input ptr_t rptr);
        return (wptr[PKG_ADDR_WIDTH] != rptr[PKG_ADDR_WIDTH]) &&
               (wptr[PKG_ADDR_WIDTH-1:0] == rptr[PKG_ADDR_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/mc_fifo_ram.sv
// Simple dual-port storage shared by all channels; registered read that holds when re is low.
module mc_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mc_sync_fifo.sv
// Single-clock multi-channel FIFO: NUM_CH logical FIFOs partitioned over one shared RAM,
// each with its own pointers, flags and flush.
module mc_sync_fifo
    import mc_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
    // Pointer helpers are sized by mc_fifo_pkg, so this must equal PKG_ADDR_WIDTH.
    parameter  int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter  int unsigned NUM_CH     = PKG_NUM_CH,
    parameter  int unsigned AFULL_LVL  = PKG_AFULL_LVL,
    localparam int unsigned CH_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CH_WIDTH-1:0]   wr_ch,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic [CH_WIDTH-1:0]   rd_ch,
    input  logic [NUM_CH-1:0]     flush,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [CH_WIDTH-1:0]   rvalid_ch,
    output logic [NUM_CH-1:0]     full,
    output logic [NUM_CH-1:0]     empty,
    output logic [NUM_CH-1:0]     almost_full,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int unsigned RAM_AW = CH_WIDTH + ADDR_WIDTH;

    ptr_t wptr [NUM_CH];
    ptr_t rptr [NUM_CH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic [RAM_AW-1:0]     waddr;
    logic [RAM_AW-1:0]     raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rdata_clr;

    always_comb begin
        full        = '0;
        empty       = '0;
        almost_full = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            full[i]        = is_full(wptr[i], rptr[i]);
            empty[i]       = is_empty(wptr[i], rptr[i]);
            almost_full[i] = 32'(occupancy(wptr[i], rptr[i])) >= AFULL_LVL;
        end
    end

    // Flush on the addressed channel suppresses both acceptance and the error pulse.
    always_comb begin
        wr_acc = !rst && wr_en && !flush[wr_ch] && !full[wr_ch];
        wr_rej = !rst && wr_en && !flush[wr_ch] &&  full[wr_ch];
        rd_acc = !rst && rd_en && !flush[rd_ch] && !empty[rd_ch];
        rd_rej = !rst && rd_en && !flush[rd_ch] &&  empty[rd_ch];
        waddr  = {wr_ch, wptr[wr_ch][ADDR_WIDTH-1:0]};
        raddr  = {rd_ch, rptr[rd_ch][ADDR_WIDTH-1:0]};
    end

    mc_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
            rvalid    <= 1'b0;
            rvalid_ch <= '0;
            wr_err    <= 1'b0;
            rd_err    <= 1'b0;
            rdata_clr <= 1'b1;
        end else begin
            if (wr_acc) begin
                wptr[wr_ch] <= wptr[wr_ch] + 1'b1;
            end
            if (rd_acc) begin
                rptr[rd_ch] <= rptr[rd_ch] + 1'b1;
                rvalid_ch   <= rd_ch;
                rdata_clr   <= 1'b0;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (flush[i]) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                end
            end
            rvalid <= rd_acc;
            wr_err <= wr_rej;
            rd_err <= rd_rej;
        end
    end

    // The RAM output register has no reset; mask it until the first read after reset.
    assign rdata = rdata_clr ? '0 : ram_rdata;

endmodule

// File: tb/tb_mc_sync_fifo.sv
// Scoreboard bench for mc_sync_fifo: per-channel queue model, directed scenarios plus random traffic.
module tb_mc_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wdata;
    logic       rd_en;
    logic [1:0] rd_ch;
    logic [3:0] flush;
    logic [7:0] rdata;
    logic       rvalid;
    logic [1:0] rvalid_ch;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] almost_full;
    logic       wr_err;
    logic       rd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rv;
        logic [7:0] d;
        logic [1:0] ch;
        logic       we;
        logic       re;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] mq [4][$];
    logic [7:0] last_rdata = 8'h00;
    bit         started = 0;

    mc_sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .NUM_CH     (4),
        .AFULL_LVL  (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wdata       (wdata),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .flush       (flush),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rvalid_ch   (rvalid_ch),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .wr_err      (wr_err),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int occ;
        if (!started) return;
        for (int c = 0; c < 4; c++) begin
            occ = mq[c].size();
            chk($sformatf("full[%0d]", c),        32'(full[c]),        32'(occ == 16));
            chk($sformatf("empty[%0d]", c),       32'(empty[c]),       32'(occ == 0));
            chk($sformatf("almost_full[%0d]", c), 32'(almost_full[c]), 32'(occ >= 12));
        end
    endtask

    // Called at a negedge: checks flags from the previous edge, drives one cycle, updates the model.
    task automatic cycle(input logic r, input logic we, input logic [1:0] wc, input logic [7:0] wd,
                         input logic re, input logic [1:0] rc, input logic [3:0] fl);
        exp_t e;
        bit   wacc, racc;
        check_flags();
        rst = r; wr_en = we; wr_ch = wc; wdata = wd; rd_en = re; rd_ch = rc; flush = fl;
        e = '{rv: 1'b0, d: last_rdata, ch: 2'd0, we: 1'b0, re: 1'b0};
        if (r) begin
            last_rdata = 8'h00;
            e.d = 8'h00;
            for (int c = 0; c < 4; c++) mq[c].delete();
            started = 1;
        end else begin
            wacc = we && !fl[wc] && (mq[wc].size() < 16);
            e.we = we && !fl[wc] && (mq[wc].size() == 16);
            racc = re && !fl[rc] && (mq[rc].size() > 0);
            e.re = re && !fl[rc] && (mq[rc].size() == 0);
            if (racc) begin
                last_rdata = mq[rc].pop_front();
                e.rv = 1'b1;
                e.d  = last_rdata;
                e.ch = rc;
            end
            if (wacc) mq[wc].push_back(wd);
            for (int c = 0; c < 4; c++) if (fl[c]) mq[c].delete();
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'h0);
    endtask

    task automatic wr(input logic [1:0] c, input logic [7:0] d);
        cycle(1'b0, 1'b1, c, d, 1'b0, 2'd0, 4'h0);
    endtask

    task automatic rd(input logic [1:0] c);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, c, 4'h0);
    endtask

    // Monitor: output for each issued cycle appears just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rvalid", 32'(rvalid), 32'(e.rv));
                chk("rdata",  32'(rdata),  32'(e.d));
                if (e.rv) chk("rvalid_ch", 32'(rvalid_ch), 32'(e.ch));
                chk("wr_err", 32'(wr_err), 32'(e.we));
                chk("rd_err", 32'(rd_err), 32'(e.re));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wdata = '0; rd_en = 1'b0; rd_ch = '0; flush = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'h0);
        idle();

        // Fill ch2 past full, then drain past empty
        for (int i = 0; i < 17; i++) wr(2'd2, 8'(i));
        for (int i = 0; i < 17; i++) rd(2'd2);
        idle();

        // Interleaved channels
        for (int i = 0; i < 6; i++) begin
            wr(2'd0, 8'hA0 + 8'(i));
            wr(2'd3, 8'h30 + 8'(i));
        end
        for (int i = 0; i < 6; i++) begin
            rd(2'd0);
            rd(2'd3);
        end

        // Pointer wrap on ch1
        wr(2'd1, 8'h00);
        for (int i = 1; i <= 40; i++) cycle(1'b0, 1'b1, 2'd1, 8'(i), 1'b1, 2'd1, 4'h0);
        rd(2'd1);

        // Full ch1 with simultaneous read and write, then empty ch1 with both
        for (int i = 0; i < 16; i++) wr(2'd1, 8'h60 + 8'(i));
        cycle(1'b0, 1'b1, 2'd1, 8'hEE, 1'b1, 2'd1, 4'h0);
        for (int i = 0; i < 15; i++) rd(2'd1);
        cycle(1'b0, 1'b1, 2'd1, 8'h77, 1'b1, 2'd1, 4'h0);
        rd(2'd1);

        // Flush ch0 with concurrent write and read on it; ch3 untouched
        for (int i = 0; i < 5; i++) wr(2'd0, 8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++) wr(2'd3, 8'hD0 + 8'(i));
        cycle(1'b0, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 4'b0001);
        rd(2'd0);
        rd(2'd3);

        // Mid-operation reset
        for (int c = 0; c < 4; c++) for (int i = 0; i < 4; i++) wr(2'(c), 8'(16 * c + i));
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'h0);
        for (int c = 0; c < 4; c++) rd(2'(c));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] fl;
            fl = '0;
            for (int c = 0; c < 4; c++) fl[c] = ($urandom_range(0, 59) == 0);
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 99) < 50), 2'($urandom_range(0, 3)), fl);
        end
        idle();
        check_flags();

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
